// File: rtl/arm_multicycle_decoder.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// plus the ALU decoder and unqualified write requests consumed by the conditional logic.
module arm_multicycle_decoder (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       NoWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    state_e state_q, state_d;

    logic       alu_op;
    logic       branch;
    logic [3:0] cmd;
    logic       s_bit;
    logic       is_cmp;

    assign cmd    = Funct[4:1];
    assign s_bit  = Funct[0];
    assign is_cmp = (cmd == 4'b1010);

    // State register; async clear to FETCH aborts any in-flight instruction.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing by opcode and load/store bit.
    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (Op)
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b01:   state_d = StMemAdr;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch; // undefined opcode: drop it silently
                endcase
            end
            StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = StFetch;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Moore datapath controls decoded from the current state.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 1'b0;
        branch    = 1'b0;
        unique case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc  = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            StExecR:  alu_op = 1'b1;
            StExecI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            StAluWb:  RegW = 1'b1;
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
        PCS = branch | (RegW & (Rd == 4'hF));
    end

    // ALU decoder: operation select and flag-write requests for data-processing instructions.
    always_comb begin
        logic arith;
        logic known;
        arith      = 1'b0;
        known      = 1'b0;
        ALUControl = 2'b00;
        if (alu_op) begin
            unique case (cmd)
                4'b0100: begin ALUControl = 2'b00; arith = 1'b1; known = 1'b1; end
                4'b0010: begin ALUControl = 2'b01; arith = 1'b1; known = 1'b1; end
                4'b0000: begin ALUControl = 2'b10; known = 1'b1; end
                4'b1100: begin ALUControl = 2'b11; known = 1'b1; end
                4'b1010: begin ALUControl = 2'b01; arith = 1'b1; known = 1'b1; end
                default: ALUControl = 2'b00; // unsupported cmd: plain ADD, flags untouched
            endcase
        end
        FlagW = {alu_op & known & s_bit, alu_op & arith & s_bit};
        // cmd is stable from the IR, so CMP suppression spans into the writeback state.
        NoWrite = is_cmp & (alu_op | (state_q == StAluWb));
    end

    // Immediate and register-source selects follow the opcode in every state.
    always_comb begin
        ImmSrc = Op;
        RegSrc = {Op == 2'b01, Op == 2'b10};
    end

endmodule

// File: tb/tb_arm_multicycle_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle output vectors, a monitor pops and
// compares them on each falling edge (or on demand for asynchronous-reset checks).
module tb_arm_multicycle_decoder;

    logic       Clk;
    logic       Reset_n;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [1:0] FlagW;
    logic       PCS, NextPC, RegW, MemW, NoWrite, IRWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;

    arm_multicycle_decoder dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .NextPC     (NextPC),
        .RegW       (RegW),
        .MemW       (MemW),
        .NoWrite    (NoWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       nm;
        logic [20:0] v;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic chk_tgl = 1'b0;

    // Output vector: FlagW,PCS,NextPC,RegW,MemW,NoWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,
    // ALUSrcB,ALUControl (17 bits) followed by ImmSrc,RegSrc (4 bits).
    function automatic logic [16:0] mk(input logic [1:0] flagw, input logic pcs,
                                       input logic nextpc, input logic regw, input logic memw,
                                       input logic nowrite, input logic irwrite,
                                       input logic adrsrc, input logic [1:0] ressrc,
                                       input logic [1:0] srca, input logic [1:0] srcb,
                                       input logic [1:0] aluctl);
        return {flagw, pcs, nextpc, regw, memw, nowrite, irwrite, adrsrc, ressrc, srca, srcb,
                aluctl};
    endfunction

    logic [16:0] vf, vd;

    initial begin
        vf = mk(2'b00, 0, 1, 0, 0, 0, 1, 0, 2'b10, 2'b01, 2'b10, 2'b00);
        vd = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00);
    end

    function automatic logic [20:0] actual();
        return {FlagW, PCS, NextPC, RegW, MemW, NoWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegSrc};
    endfunction

    task automatic push(input string nm, input logic [20:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        q.push_back(e);
    endtask

    // Monitor: compare one expected vector per falling edge or on-demand strobe.
    initial begin
        exp_t e;
        logic [20:0] a;
        forever begin
            @(negedge Clk or chk_tgl);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = actual();
                n_total++;
                if (a === e.v) n_pass++;
                else $display("FAIL %s: got %b, expected %b", e.nm, a, e.v);
            end
        end
    end

    // Runs one instruction starting in FETCH; cycles are FETCH, DECODE, c2, c3, c4 (first n).
    task automatic run(input string nm, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic [3:0] tail, input int n,
                       input logic [16:0] c2, input logic [16:0] c3, input logic [16:0] c4);
        logic [16:0] cs[5];
        cs = '{vf, vd, c2, c3, c4};
        Op    = op;
        Funct = fn;
        Rd    = rd;
        for (int i = 0; i < n; i++) begin
            push($sformatf("%s[%0d]", nm, i), {cs[i], tail});
            @(posedge Clk);
            #1;
        end
    endtask

    localparam logic [3:0] T00 = 4'b0000;
    localparam logic [3:0] T01 = 4'b0110;
    localparam logic [3:0] T10 = 4'b1001;
    localparam logic [3:0] T11 = 4'b1100;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d checks done", n_total);
        $fatal(1);
    end

    initial begin
        logic [16:0] z;
        z       = '0;
        Reset_n = 1'b0;
        Op      = 2'b00;
        Funct   = 6'b000000;
        Rd      = 4'h0;
        @(posedge Clk);
        #1;
        push("in_reset", {vf, T00});
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // ADDS R1,R2,R3
        run("adds", 2'b00, 6'b001001, 4'd1, T00, 4,
            mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00),
            mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // LDR R2
        run("ldr", 2'b01, 6'b011001, 4'd2, T01, 5,
            mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00),
            mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00),
            mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00));
        // STR R3
        run("str", 2'b01, 6'b011000, 4'd3, T01, 4,
            mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00),
            mk(2'b00, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // B
        run("b", 2'b10, 6'b100000, 4'd0, T10, 3,
            mk(2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00), z, z);
        // CMPS
        run("cmp", 2'b00, 6'b010101, 4'd0, T00, 4,
            mk(2'b11, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01),
            mk(2'b00, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // ADD R15, #imm (no S)
        run("add_pc", 2'b00, 6'b101000, 4'd15, T00, 4,
            mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00),
            mk(2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // ORRS R4, #imm: logical, so only NZ flags
        run("orrs", 2'b00, 6'b111001, 4'd4, T00, 4,
            mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11),
            mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // ANDS R6
        run("ands", 2'b00, 6'b000001, 4'd6, T00, 4,
            mk(2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10),
            mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // SUB R5 (no S)
        run("sub", 2'b00, 6'b000100, 4'd5, T00, 4,
            mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01),
            mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // EORS: unsupported cmd -> ADD, no flag write
        run("eors", 2'b00, 6'b000011, 4'd7, T00, 4,
            mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00),
            mk(2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), z);
        // LDR into R15: PCS in MEMWB
        run("ldr_pc", 2'b01, 6'b011001, 4'd15, T01, 5,
            mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00),
            mk(2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00),
            mk(2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00));
        // Undefined opcode: FETCH, DECODE, back to FETCH
        run("undef", 2'b11, 6'b001001, 4'd15, T11, 2, z, z, z);

        // STR aborted by asynchronous reset while in MEMWR
        Op    = 2'b01;
        Funct = 6'b011000;
        Rd    = 4'd8;
        push("abort_fetch", {vf, T01});
        @(posedge Clk); #1;
        push("abort_decode", {vd, T01});
        @(posedge Clk); #1;
        push("abort_memadr",
             {mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00), T01});
        @(posedge Clk); #1;
        push("abort_memwr",
             {mk(2'b00, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), T01});
        @(negedge Clk); #2;
        Reset_n = 1'b0;
        #1;
        push("async_reset", {vf, T01});
        chk_tgl = ~chk_tgl;
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Normal operation after the abort
        run("post_reset_b", 2'b10, 6'b100000, 4'd0, T10, 3,
            mk(2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00), z, z);
        push("final_fetch", {vf, T10});

        @(negedge Clk);
        @(negedge Clk);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_decoder.md
# arm_multicycle_decoder

Multicycle control unit for the ARM datapath. It sits directly upstream of the conditional logic stage. Each instruction is sequenced through a Moore FSM (fetch, decode, execute, memory, writeback), and the block issues datapath select/enable controls each cycle. It also produces the unqualified control requests `PCS`, `RegW`, `MemW`, `FlagW` and `NoWrite`, which the conditional logic gates with the condition check.

## Interface
Parameters: none.
- `Clk` in 1: system clock; all state changes on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset; forces FETCH.
- `Op` in 2: instruction bits [27:26], from the instruction register.
- `Funct` in 6: instruction bits [25:20]; [5]=I, [4:1]=cmd, [0]=S (DP) or L (memory).
- `Rd` in 4: instruction bits [15:12].
- `FlagW` out 2: flag write request; [1]=NZ, [0]=CV.
- `PCS` out 1: PC-write request (branch or write to R15).
- `NextPC` out 1: unconditional PC increment enable.
- `RegW` out 1: register write request.
- `MemW` out 1: memory write request.
- `NoWrite` out 1: suppress register write (CMP).
- `IRWrite` out 1: instruction register enable.
- `AdrSrc` out 1: 0=PC, 1=ALU result.
- `ResultSrc` out 2: 00=ALUOut, 01=Data, 10=ALUResult.
- `ALUSrcA` out 2: 0=RD1, 1=PC.
- `ALUSrcB` out 2: 00=RD2, 01=ExtImm, 10=constant 4.
- `ALUControl` out 2: 00=ADD, 01=SUB, 10=AND, 11=ORR.
- `ImmSrc` out 2: equal to `Op`.
- `RegSrc` out 2: [0]=(Op==10), [1]=(Op==01).

## Operation
- The FSM has ten states, encoded 0–9: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH always goes to DECODE.
- DECODE transitions by `Op`:
  - `Op`=01 → MEMADR.
  - `Op`=00 with `Funct[5]`=0 → EXECR.
  - `Op`=00 with `Funct[5]`=1 → EXECI.
  - `Op`=10 → BRANCH.
  - `Op`=11 (undefined) → FETCH, with no side effects.
- MEMADR goes to MEMRD if `Funct[0]`=1, else to MEMWR.
- Remaining transitions: MEMRD→MEMWB→FETCH; MEMWR→FETCH; EXECR/EXECI→ALUWB→FETCH; BRANCH→FETCH.
- Per-state outputs (anything not listed is 0):
  - FETCH: `IRWrite`=1, `NextPC`=1, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, `AdrSrc`=0.
  - DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - MEMADR: `ALUSrcB`=01.
  - MEMRD: `AdrSrc`=1.
  - MEMWB: `ResultSrc`=01, `RegW`=1.
  - MEMWR: `AdrSrc`=1, `MemW`=1.
  - EXECR: `ALUSrcB`=00, ALUOp=1.
  - EXECI: `ALUSrcB`=01, ALUOp=1.
  - ALUWB: `RegW`=1.
  - BRANCH: `ALUSrcB`=01, `ResultSrc`=10, Branch=1.
- ALU decode when ALUOp=0: `ALUControl`=00, `FlagW`=00, `NoWrite`=0.
- ALU decode when ALUOp=1, by cmd:
  - cmd 0100 → ADD; 0010 → SUB; 0000 → AND; 1100 → ORR.
  - cmd 1010 → SUB with `NoWrite`=1.
  - Any other cmd → ADD with `FlagW`=00.
- Flag write, ALUOp=1 only: `FlagW[1]`=S; `FlagW[0]`=S & (ADD|SUB|CMP).
- `NoWrite` is held for CMP through ALUWB, since cmd is stable from the instruction register.
- `PCS` = Branch | (RegW & (`Rd`==15)).
- `ImmSrc` and `RegSrc` are combinational from `Op` in every state.

## Timing
- Outputs are Moore, decoded from the registered state plus stable instruction-register fields; there is no output register.
- `Reset_n` low clears the state to FETCH asynchronously.
  - During reset and on the first cycle after it, outputs are the FETCH values: `IRWrite`=1, `NextPC`=1, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10; all other outputs 0.
- Reset asserted mid-instruction aborts it. No `RegW`/`MemW` is asserted after the asynchronous clear.
- Cycles per instruction:
  - LDR: 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB).
  - STR: 4.
  - DP: 4.
  - B: 3.
  - Undefined: 2.
- `FlagW` is asserted only in EXECR/EXECI, one cycle before ALUWB. The conditional logic captures flags on the falling edge of that cycle.
- `Op`/`Funct`/`Rd` must hold from DECODE until the next FETCH. `IRWrite` is 0 outside FETCH, which guarantees this.

## Test plan
- ADDS R1,R2,R3 (`Op`=00, `Funct`=001001, `Rd`=1) → states FETCH, DECODE, EXECR, ALUWB, FETCH:
  - `FlagW`=11 and `ALUControl`=00 in EXECR.
  - `RegW`=1 and `PCS`=0 in ALUWB.
- LDR (`Op`=01, `Funct[0]`=1) → 5-cycle sequence; `AdrSrc`=1 in MEMRD; `ResultSrc`=01 and `RegW`=1 in MEMWB.
- STR (`Funct[0]`=0) → `MemW`=1 only in MEMWR, then FETCH; `RegW` never asserted.
- B (`Op`=10) → `PCS`=1 in BRANCH; returns to FETCH after 3 cycles.
- CMP (`Funct`=010101) → `ALUControl`=01, `FlagW`=11, `NoWrite`=1. ADD with `Rd`=15 → `PCS`=1 in ALUWB.
- Reset and undefined opcode:
  - Pull `Reset_n` low in MEMWR → state is FETCH immediately, `MemW`=0 without waiting for a clock edge.
  - `Op`=11 → returns to FETCH after DECODE; no write requests asserted.
